// File: rtl/spi_tx_fifo_pkg.sv
// Shared definitions for the SPI transmit FIFO: sizing helper, handshake
// state encoding and the default post-reset output pattern.
package spi_tx_fifo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } tx_state_e;

  // Replicated across WIDTH to form the all-ones default of TXF_Data_Out.
  localparam logic DEFAULT_RESET_BIT = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_tx_fifo_mem.sv
// DEPTH x WIDTH storage with one synchronous write port and one asynchronous
// read port. Contents are not reset.
module spi_tx_fifo_mem
  import spi_tx_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/spi_tx_fifo.sv
// Transmit FIFO feeding the SPI shift register: host write port, occupancy
// flags, sticky overflow and the RcvrRdyN/DataRdyN four-phase head offer.
module spi_tx_fifo
  import spi_tx_fifo_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 4,
  parameter int               AFULL_LVL  = DEPTH - 1,
  parameter logic [WIDTH-1:0] RESET_DATA = {WIDTH{DEFAULT_RESET_BIT}}
) (
  input  logic                      TXF_Clk,
  input  logic                      TXF_Rst,
  input  logic [WIDTH-1:0]          TXF_Data_In,
  input  logic                      TXF_WriteN,
  input  logic                      TXF_CmdN,
  input  logic                      TXF_Flush,
  input  logic                      TXF_RcvrRdyN,
  input  logic                      TXF_RcvrLoadingN,
  output logic [WIDTH-1:0]          TXF_Data_Out,
  output logic                      TXF_DataRdyN,
  output logic                      TXF_Full,
  output logic                      TXF_AlmostFull,
  output logic                      TXF_Empty,
  output logic [clog2(DEPTH+1)-1:0] TXF_Count,
  output logic                      TXF_Overflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  tx_state_e        state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             rdy_q, rdy_d, loading_q, loading_d;
  logic             wr_req, wr_acc, pop;
  logic [WIDTH-1:0] head_data;

  spi_tx_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (TXF_Clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (TXF_Data_In),
    .raddr (rd_ptr_q),
    .rdata (head_data)
  );

  always_comb begin
    rdy_d     = ~TXF_RcvrRdyN;
    loading_d = ~TXF_RcvrLoadingN;
    wr_req    = TXF_CmdN & ~TXF_WriteN & ~TXF_Flush;
    // loading_q is deliberately absent: it only steers TXF_Full.
    wr_acc    = wr_req & (count_q != DEPTH_C);
    state_d   = state_q;
    dout_d    = dout_q;
    pop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rdy_q && (count_q != '0)) begin
          state_d = ST_OFFER;
          dout_d  = head_data;
        end
      end
      ST_OFFER: begin
        if (!rdy_q) begin
          state_d = ST_IDLE;
          pop     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

    case ({wr_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A write against a full FIFO is dropped even if a pop frees a slot this edge.
    ovf_d = ovf_q | (wr_req & (count_q == DEPTH_C));

    if (TXF_Flush) begin
      state_d  = ST_IDLE;
      dout_d   = RESET_DATA;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge TXF_Clk or posedge TXF_Rst) begin
    if (TXF_Rst) begin
      state_q   <= ST_IDLE;
      dout_q    <= RESET_DATA;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rdy_q     <= 1'b0;
      loading_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rdy_q     <= rdy_d;
      loading_q <= loading_d;
    end
  end

  assign TXF_Data_Out   = dout_q;
  assign TXF_DataRdyN   = (state_q != ST_OFFER);
  assign TXF_Full       = (count_q == DEPTH_C) | loading_q;
  assign TXF_AlmostFull = (count_q >= AFULL_C);
  assign TXF_Empty      = (count_q == '0);
  assign TXF_Count      = count_q;
  assign TXF_Overflow   = ovf_q;

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Randomised and directed bench for spi_tx_fifo (WIDTH=8, DEPTH=4) against a
// queue-based model of the FIFO and its offer/withdraw handshake.
module tb_spi_tx_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       wn, cmdn, flush, rdyn, loadn;
  logic [7:0] dout;
  logic       drdyn, full, afull, empty, ovf;
  logic [2:0] cnt;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] q[$];
  logic       m_rdy, m_load, m_offer, m_ovf;
  logic [7:0] m_dout;

  always #5 clk = ~clk;

  spi_tx_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .TXF_Clk          (clk),
    .TXF_Rst          (rst),
    .TXF_Data_In      (din),
    .TXF_WriteN       (wn),
    .TXF_CmdN         (cmdn),
    .TXF_Flush        (flush),
    .TXF_RcvrRdyN     (rdyn),
    .TXF_RcvrLoadingN (loadn),
    .TXF_Data_Out     (dout),
    .TXF_DataRdyN     (drdyn),
    .TXF_Full         (full),
    .TXF_AlmostFull   (afull),
    .TXF_Empty        (empty),
    .TXF_Count        (cnt),
    .TXF_Overflow     (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_rdy   = 1'b0;
    m_load  = 1'b0;
    m_offer = 1'b0;
    m_ovf   = 1'b0;
    m_dout  = 8'hFF;
  endfunction

  // One clock edge of the FIFO as described behaviourally, using pre-edge inputs.
  function automatic void model_edge();
    bit wr;
    bit was_full;
    if (flush) begin
      q.delete();
      m_offer = 1'b0;
      m_ovf   = 1'b0;
      m_dout  = 8'hFF;
    end else begin
      wr       = cmdn && !wn;
      was_full = (q.size() == DEPTH);
      if (!m_offer && m_rdy && q.size() > 0) begin
        m_offer = 1'b1;
        m_dout  = q[0];
      end else if (m_offer && !m_rdy) begin
        m_offer = 1'b0;
        void'(q.pop_front());
      end
      if (wr && !was_full) q.push_back(din);
      if (wr && was_full) m_ovf = 1'b1;
    end
    m_rdy  = !rdyn;
    m_load = !loadn;
  endfunction

  task automatic check_all();
    chk("data_out", 32'(dout), 32'(m_dout));
    chk("data_rdy_n", 32'(drdyn), 32'(!m_offer));
    chk("count", 32'(cnt), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'((q.size() == DEPTH) || m_load));
    chk("almost_full", 32'(afull), 32'(q.size() >= DEPTH - 1));
    chk("overflow", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic write1(input logic [7:0] v);
    din = v; wn = 1'b0; cmdn = 1'b1;
    step();
    wn = 1'b1;
  endtask

  task automatic handshake(output logic [7:0] got);
    rdyn = 1'b0;
    step();
    chk("offer_not_early", 32'(drdyn), 32'd1);
    step();
    chk("offer_low", 32'(drdyn), 32'd0);
    got = dout;
    rdyn = 1'b1;
    step();
    step();
    chk("pop_high", 32'(drdyn), 32'd1);
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] expq[$];
    logic [7:0] v;
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33; exp_seq[3] = 8'h44;

    rst = 1'b1; din = '0; wn = 1'b1; cmdn = 1'b1; flush = 1'b0;
    rdyn = 1'b1; loadn = 1'b1;
    model_reset();
    #12;
    check_all();
    rst = 1'b0;
    step();
    step();
    chk("rst_dout", 32'(dout), 32'hFF);
    chk("rst_empty", 32'(empty), 32'd1);

    // Fill, then overflow with 0x55.
    for (int i = 0; i < 4; i++) write1(exp_seq[i]);
    chk("fill_count", 32'(cnt), 32'd4);
    chk("fill_full", 32'(full), 32'd1);
    write1(8'h55);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(cnt), 32'd4);

    for (int i = 0; i < 4; i++) begin
      handshake(got);
      chk("drain_data", 32'(got), 32'(exp_seq[i]));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    rdyn = 1'b0;
    step(); step(); step();
    chk("no_offer_empty", 32'(drdyn), 32'd1);
    rdyn = 1'b1;
    step();

    // Write coinciding with the pop edge, across three pointer wraps.
    flush = 1'b1; step(); flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = 8'($urandom);
      expq.push_back(v);
      write1(v);
    end
    for (int i = 0; i < 12; i++) begin
      rdyn = 1'b0;
      step(); step();
      got = dout;
      chk("wrap_head", 32'(got), 32'(expq.pop_front()));
      rdyn = 1'b1;
      step();
      v = (i == 11) ? 8'hA5 : 8'($urandom);
      expq.push_back(v);
      din = v; wn = 1'b0; cmdn = 1'b1;
      step();
      wn = 1'b1;
      chk("wrap_count", 32'(cnt), 32'd3);
    end
    for (int i = 0; i < 3; i++) begin
      handshake(got);
      chk("wrap_tail", 32'(got), 32'(expq.pop_front()));
    end

    // Loading raises Full but does not block a write.
    flush = 1'b1; step(); flush = 1'b0;
    write1(8'h01);
    loadn = 1'b0;
    step();
    chk("load_full", 32'(full), 32'd1);
    write1(8'h66);
    chk("load_count", 32'(cnt), 32'd2);
    loadn = 1'b1;
    step();

    // Flush aborts an active offer.
    flush = 1'b1; step(); flush = 1'b0;
    write1(8'h11);
    rdyn = 1'b0;
    step(); step();
    chk("pre_flush_dout", 32'(dout), 32'h11);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_rdyn", 32'(drdyn), 32'd1);
    chk("flush_dout", 32'(dout), 32'hFF);
    chk("flush_count", 32'(cnt), 32'd0);

    // Asynchronous reset mid-handshake while a write is being presented.
    write1(8'h22);
    step(); step();
    din = 8'h77; wn = 1'b0; cmdn = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_rdyn", 32'(drdyn), 32'd1);
    chk("arst_dout", 32'(dout), 32'hFF);
    chk("arst_count", 32'(cnt), 32'd0);
    check_all();
    wn = 1'b1; rdyn = 1'b1;
    #3 rst = 1'b0;
    step();

    // Random phase.
    for (int i = 0; i < 2000; i++) begin
      din   = 8'($urandom);
      wn    = 1'($urandom_range(0, 1));
      cmdn  = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 59) == 0);
      loadn = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) rdyn = ~rdyn;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_tx_fifo.md
# spi_tx_fifo

Parametrised transmit FIFO between the host write port and the SPI shift register. It is the multi-entry successor to the single-entry transmit buffer.
- Host writes are gated by command mode.
- The head entry is offered to the shift register with the existing RcvrRdyN / DataRdyN four-phase handshake.
- Adds configurable depth and width, occupancy count, almost-full, flush and sticky overflow.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, entries; power of two, ≥2
- AFULL_LVL, DEPTH-1, TXF_AlmostFull asserts when count ≥ AFULL_LVL (1..DEPTH)
- RESET_DATA, all ones, value of TXF_Data_Out after reset or flush
- TXF_Clk  in  1  single clock; all state updates on rising edge
- TXF_Rst  in  1  asynchronous, active-high reset
- TXF_Data_In  in  WIDTH  write data
- TXF_WriteN  in  1  active-low write strobe, one entry per cycle held low
- TXF_CmdN  in  1  low = command mode; writes ignored
- TXF_Flush  in  1  synchronous clear, active high
- TXF_RcvrRdyN  in  1  shift register ready for data, active low, synchronous to TXF_Clk
- TXF_RcvrLoadingN  in  1  shift register loading, active low, synchronous
- TXF_Data_Out  out  WIDTH  offered head entry
- TXF_DataRdyN  out  1  head entry valid on TXF_Data_Out, active low
- TXF_Full  out  1  count==DEPTH OR loading_q
- TXF_AlmostFull  out  1  count ≥ AFULL_LVL
- TXF_Empty  out  1  count==0
- TXF_Count  out  clog2(DEPTH+1)  occupancy
- TXF_Overflow  out  1  sticky: a write was dropped

## Operation
- Registered inputs: rdy_q = ~TXF_RcvrRdyN and loading_q = ~TXF_RcvrLoadingN, sampled every edge.
- Write accepted iff TXF_CmdN=1, TXF_WriteN=0, TXF_Flush=0 and pre-edge count<DEPTH.
  - On accept: store at wr_ptr; wr_ptr+1 mod DEPTH.
  - If the same conditions hold but count==DEPTH: data dropped, Overflow←1. This applies even with a simultaneous pop.
- loading_q only affects TXF_Full, which holds the host off. It never blocks an accepted write.
- Handshake FSM, two states:
  - IDLE (DataRdyN=1) → OFFER when rdy_q=1 and count>0. On that edge TXF_Data_Out ← mem[rd_ptr] and DataRdyN←0.
  - OFFER (DataRdyN=0) → IDLE when rdy_q=0. Pop on that edge: rd_ptr+1 mod DEPTH, count−1, DataRdyN←1. TXF_Data_Out holds its value.
  - While in OFFER, TXF_Data_Out and the head entry are frozen.
- Simultaneous accepted write and pop: count unchanged; both pointers advance.
- Pointers are log2(DEPTH) bits with natural wrap. Count is a separate register (full/empty are unambiguous).
- TXF_Flush has priority over write and pop. Next edge:
  - pointers and count ← 0
  - FSM ← IDLE, DataRdyN ← 1
  - Overflow ← 0
  - TXF_Data_Out ← RESET_DATA
  - A flush during OFFER aborts the offer; the receiver sees DataRdyN rise without rdy_q falling.
- Reset (async) gives the same state as flush, plus rdy_q=0 and loading_q=0. Reset values of all outputs:
  - Data_Out=RESET_DATA
  - DataRdyN=1, Full=0, AlmostFull=0 (AFULL_LVL≥1)
  - Empty=1, Count=0, Overflow=0
- Reset asserted mid-handshake drops all entries. No partial pop occurs.

## Timing
- Write at edge N: Count, Empty, AlmostFull and Full update at N (registered, visible after N).
- Write-to-offer, empty FIFO with rdy_q already 1: write at N, DataRdyN low at N+1.
- RcvrRdyN falling before edge M (FIFO non-empty): rdy_q=1 at M, DataRdyN low at M+1.
- RcvrRdyN rising before edge K: rdy_q=0 at K, pop and DataRdyN high at K+1.
- Minimum entry turnaround, one offer per entry: 4 cycles.
- TXF_Full reflects loading_q: one cycle after the RcvrLoadingN transition.
- All outputs are registered or decoded from registers only. No combinational input→output path.

## Structure
- Shared package spi_tx_fifo_pkg:
  - clog2 function
  - FSM state encoding (ST_IDLE, ST_OFFER)
  - default RESET_DATA constant
- Sub-module spi_tx_fifo_mem: DEPTH×WIDTH register array, one write port and one asynchronous read port. It has no reset; contents are undefined until written.
- Top: pointers, count, handshake FSM, input registers, flags.

## Test plan
- Reset then idle, WIDTH=8, DEPTH=4 → Data_Out=0xFF, DataRdyN=1, Empty=1, Count=0, Full=0, Overflow=0.
- Write 0x11,0x22,0x33,0x44 with RcvrRdyN high → Count=4, Full=1, AlmostFull=1. Fifth write 0x55 → Overflow=1, Count stays 4.
- Four full handshakes after the previous case → Data_Out sequence 0x11,0x22,0x33,0x44, each DataRdyN low 1 cycle after rdy_q. Ends Empty=1; 0x55 never appears.
- Count=3, RcvrRdyN held high so that the pop edge and a write of 0xA5 coincide → Count stays 3, 0xA5 popped last. Repeat across 3 wraps of the pointers.
- RcvrLoadingN low with Count=1 → Full=1 one cycle later. A write of 0x66 is still accepted, Count=2.
- Flush during OFFER (Data_Out=0x11) → next edge DataRdyN=1, Count=0, Data_Out=0xFF, Overflow=0. Async reset asserted mid-write gives the same result immediately.
